// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//
// Adds two (4*NIBBLES)-bit operands plus a carry-in, one nibble per clock,
// by driving an external combinational 4-bit ripple adder and capturing its
// results. The carry between nibbles is held in a register, so the only
// ripple path is inside the external 4-bit adder itself.
//
// Ports:
//   CLK     in   clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   START   in   request, accepted when not in RUN
//   A, B    in   operands (4*NIBBLES bits), latched on acceptance
//   CIN     in   carry-in, latched on acceptance
//   BUSY    out  high while nibbles are being processed (registered)
//   DONE    out  one-cycle pulse; SUM/COUT valid from this cycle on
//   SUM     out  result, held until the next completion
//   COUT    out  final carry-out, held with SUM
//   ADD_X   out  current nibble of latched A to the 4-bit adder
//   ADD_Y   out  current nibble of latched B to the 4-bit adder
//   ADD_C0  out  registered carry to the 4-bit adder
//   ADD_S   in   sum nibble from the 4-bit adder
//   ADD_C4  in   carry-out from the 4-bit adder
// ---------------------------------------------------------------------------
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 CIN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*NIBBLES-1:0] SUM,
  output logic                 COUT,
  output logic [3:0]           ADD_X,
  output logic [3:0]           ADD_Y,
  output logic                 ADD_C0,
  input  logic [3:0]           ADD_S,
  input  logic                 ADD_C4
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_work;
  logic [W-1:0]     r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [W-1:0]     w_work_next;

  // START is honoured in IDLE and in FIN (back-to-back), never during RUN.
  assign w_accept = START && (r_state != S_RUN);
  assign w_last   = (r_idx == LAST_IDX);

  // State register; BUSY/DONE are registered from the next state so they
  // carry no combinational path from START.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_RUN);
      r_done  <= (w_state_next == S_FIN);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (START) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_FIN;
      S_FIN:   w_state_next = START ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs: adder operands come only from registers and are forced to zero
  // outside RUN.
  always_comb begin
    BUSY   = r_busy;
    DONE   = r_done;
    SUM    = r_sum;
    COUT   = r_cout;
    ADD_X  = 4'h0;
    ADD_Y  = 4'h0;
    ADD_C0 = 1'b0;
    if (r_state == S_RUN) begin
      for (int j = 0; j < NIBBLES; j++) begin
        if (r_idx == IDX_W'(j)) begin
          ADD_X = r_a[4*j +: 4];
          ADD_Y = r_b[4*j +: 4];
        end
      end
      ADD_C0 = r_carry;
    end
  end

  // Work register with the adder's current nibble dropped into slot idx.
  // Used both for the per-cycle update and for the final SUM capture, so the
  // last nibble reaches SUM on the same edge.
  always_comb begin
    w_work_next = r_work;
    for (int j = 0; j < NIBBLES; j++) begin
      if (r_idx == IDX_W'(j)) begin
        w_work_next[4*j +: 4] = ADD_S;
      end
    end
  end

  // Datapath registers. ADD_S/ADD_C4 are sampled only in RUN, so unknowns on
  // the adder outside RUN never reach SUM/COUT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_carry <= CIN;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_work  <= w_work_next;
      r_carry <= ADD_C4;
      if (w_last) begin
        r_sum  <= w_work_next;
        r_cout <= ADD_C4;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed bench for nibble_serial_adder. Two instances share the clock and
// reset: a NIBBLES=4 unit for the main sequences and a NIBBLES=1 unit for the
// exhaustive small-width sweep. Each instance gets its own behavioural 4-bit
// ripple adder on the ADD_* ports.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder;

  logic        CLK;
  logic        RST_N;

  // NIBBLES=4 instance
  logic        start4;
  logic [15:0] a4, b4;
  logic        cin4;
  logic        busy4, done4, cout4;
  logic [15:0] sum4;
  logic [3:0]  x4, y4, s4;
  logic        c04, c44;

  // NIBBLES=1 instance
  logic        start1;
  logic [3:0]  a1, b1;
  logic        cin1;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;
  logic [3:0]  x1, y1, s1;
  logic        c01, c41;

  int n_checks;
  int n_errors;

  nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .START(start4), .A(a4), .B(b4), .CIN(cin4),
    .BUSY(busy4), .DONE(done4), .SUM(sum4), .COUT(cout4),
    .ADD_X(x4), .ADD_Y(y4), .ADD_C0(c04), .ADD_S(s4), .ADD_C4(c44)
  );

  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(start1), .A(a1), .B(b1), .CIN(cin1),
    .BUSY(busy1), .DONE(done1), .SUM(sum1), .COUT(cout1),
    .ADD_X(x1), .ADD_Y(y1), .ADD_C0(c01), .ADD_S(s1), .ADD_C4(c41)
  );

  // 4-bit ripple adders on the ADD_* ports
  assign {c44, s4} = {1'b0, x4} + {1'b0, y4} + {4'b0, c04};
  assign {c41, s1} = {1'b0, x1} + {1'b0, y1} + {4'b0, c01};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one START on the 4-nibble unit and step through RUN, checking BUSY,
  // ADD_X and ADD_C0 each RUN cycle against the supplied expectations.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [3:0] exp_c0 [4], input string tag);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4 = 16'h0; b4 = 16'h0; cin4 = 1'b0;   // operands may change after acceptance
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, 32'(busy4), 32'd1);
      check({tag, "_x"},    32'(x4),    32'(a[4*i +: 4]));
      check({tag, "_c0"},   32'(c04),   32'(exp_c0[i][0]));
      check({tag, "_done_early"}, 32'(done4), 32'd0);
      tick();
    end
  endtask

  logic [3:0] c0_none [4];
  logic [3:0] c0_ffff [4];
  logic       saw_done;

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST_N  = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    c0_none = '{4'd0, 4'd0, 4'd0, 4'd0};
    c0_ffff = '{4'd0, 4'd1, 4'd1, 4'd1};

    repeat (3) tick();
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_sum",  32'(sum4),  32'd0);
    check("rst_cout", 32'(cout4), 32'd0);
    check("rst_x",    32'(x4),    32'd0);
    RST_N = 1'b1;
    repeat (2) tick();

    // Case 1: 1234 + 4321
    run4(16'h1234, 16'h4321, 1'b0, c0_none, "c1");
    check("c1_done", 32'(done4), 32'd1);
    check("c1_busy_fin", 32'(busy4), 32'd0);
    check("c1_sum",  32'(sum4),  32'h5555);
    check("c1_cout", 32'(cout4), 32'd0);
    check("c1_x_fin", 32'(x4),   32'd0);
    tick();
    check("c1_done_pulse", 32'(done4), 32'd0);
    check("c1_sum_hold",   32'(sum4),  32'h5555);

    // Case 2: FFFF + 0001, carry ripples through the register
    run4(16'hFFFF, 16'h0001, 1'b0, c0_ffff, "c2");
    check("c2_done", 32'(done4), 32'd1);
    check("c2_sum",  32'(sum4),  32'h0000);
    check("c2_cout", 32'(cout4), 32'd1);
    tick();

    // Case 3: FFFF + FFFF + 1, then hold across idle cycles
    run4(16'hFFFF, 16'hFFFF, 1'b1, '{4'd1, 4'd1, 4'd1, 4'd1}, "c3");
    check("c3_done", 32'(done4), 32'd1);
    check("c3_sum",  32'(sum4),  32'hFFFF);
    check("c3_cout", 32'(cout4), 32'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
      tick();
      check("c3_hold_sum",  32'(sum4),  32'hFFFF);
      check("c3_hold_cout", 32'(cout4), 32'd1);
    end

    // Case 4: START pulses during RUN ignored; START in FIN accepted
    a4 = 16'h00FF; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      start4 = i[0];
      a4 = 16'hAAAA;
      check("c4_busy", 32'(busy4), 32'd1);
      tick();
    end
    check("c4_done", 32'(done4), 32'd1);
    check("c4_sum",  32'(sum4),  32'h0100);
    check("c4_cout", 32'(cout4), 32'd0);
    a4 = 16'h8000; b4 = 16'h8000; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0; a4 = 16'h0; b4 = 16'h0;
    check("c4_b2b_busy", 32'(busy4), 32'd1);
    check("c4_b2b_done", 32'(done4), 32'd0);
    repeat (4) tick();
    check("c4_b2b_done2", 32'(done4), 32'd1);
    check("c4_b2b_sum",   32'(sum4),  32'h0000);
    check("c4_b2b_cout",  32'(cout4), 32'd1);
    tick();

    // Case 5: async reset during the second RUN cycle
    a4 = 16'h1234; b4 = 16'h4321; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    check("c5_busy_pre", 32'(busy4), 32'd1);
    check("c5_cout_pre", 32'(cout4), 32'd1);
    #1 RST_N = 1'b0;
    #1;
    check("c5_busy", 32'(busy4), 32'd0);
    check("c5_done", 32'(done4), 32'd0);
    check("c5_sum",  32'(sum4),  32'd0);
    check("c5_cout", 32'(cout4), 32'd0);
    tick();
    RST_N = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done4 !== 1'b0 || busy4 !== 1'b0) saw_done = 1'b1;
    end
    check("c5_no_done_after", 32'(saw_done), 32'd0);
    check("c5_sum_after",     32'(sum4),     32'd0);

    // Case 6: NIBBLES=1 exhaustive
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      a1 = v[3:0]; b1 = v[7:4]; cin1 = v[8]; start1 = 1'b1;
      tick();
      start1 = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0;
      check("c6_busy", 32'(busy1), 32'd1);
      tick();
      check("c6_done", 32'(done1), 32'd1);
      check("c6_result", 32'({cout1, sum1}),
            32'({1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]}));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
